// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-port multiplier arbiter and its times-table ROM.
// Holds the operand, result and address widths, the wait-counter width, the
// controller state encoding, the requester IDs, and the ROM content function.
package mult_pkg;

  localparam int unsigned OPERAND_W = 3;
  localparam int unsigned RESULT_W  = 6;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // ROM word for address {a,b}: the unsigned product a*b (at most 49, fits 6 bits).
  function automatic logic [RESULT_W-1:0] times_entry(input logic [ADDR_W-1:0] addr);
    logic [RESULT_W-1:0] a;
    logic [RESULT_W-1:0] b;
    a = RESULT_W'(addr[ADDR_W-1 -: OPERAND_W]);
    b = RESULT_W'(addr[OPERAND_W-1:0]);
    return a * b;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Bus bundle between the multiplier arbiter and its environment.
// Carries both requester handshakes (operands in, result out), the external
// ROM read port, and the busy flag.
//   slave  : arbiter side (drives readies, resp valids, result, ROM address/enable, busy)
//   master : environment side (drives request valids/operands, resp readies, ROM data)
interface mult_arbiter_if;
  import mult_pkg::*;

  logic                  req0_valid;
  logic                  req1_valid;
  logic [OPERAND_W-1:0]  req0_a;
  logic [OPERAND_W-1:0]  req0_b;
  logic [OPERAND_W-1:0]  req1_a;
  logic [OPERAND_W-1:0]  req1_b;
  logic                  req0_ready;
  logic                  req1_ready;
  logic                  resp0_valid;
  logic                  resp1_valid;
  logic                  resp0_ready;
  logic                  resp1_ready;
  logic [RESULT_W-1:0]   resp_result;
  logic                  rom_en;
  logic [ADDR_W-1:0]     rom_addr;
  logic [RESULT_W-1:0]   rom_dout;
  logic                  busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  resp0_ready, resp1_ready, rom_dout,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result,
    output rom_en, rom_addr, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output resp0_ready, resp1_ready, rom_dout,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result,
    input  rom_en, rom_addr, busy
  );

endinterface

// File: rtl/mult_arbiter_rom.sv
// times_table_rom: 64-entry registered-output ROM, address {a,b} -> a*b.
// One cycle of latency from en to dout; dout holds while en is low.
//   clk  : rising-edge clock
//   en   : read enable
//   addr : {a[2:0], b[2:0]}
//   dout : product, registered
module times_table_rom
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [RESULT_W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (en) begin
      dout <= times_entry(addr);
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that serves two requesters' 3x3-bit
// multiplications by reading an external times-table ROM.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : mult_arbiter_if.slave -- request/response handshakes for
//              requesters 0 and 1, ROM read port (rom_en/rom_addr/rom_dout), busy
// ROM_LATENCY (1..3) is the cycle count from rom_en to valid rom_dout.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  mult_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [RESULT_W-1:0]  result_q, result_d;

  logic                 pick;
  logic                 rdy0, rdy1;
  logic                 rv0, rv1;
  logic                 rom_en;
  logic [RESULT_W-1:0]  res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= REQ0;
      last_q   <= REQ1;
      addr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    result_d = result_q;
    pick     = REQ0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    rv0      = 1'b0;
    rv1      = 1'b0;
    rom_en   = 1'b0;
    res      = '0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // With both pending, the winner is whoever did not win last time.
          if (bus.req0_valid && bus.req1_valid) begin
            pick = ~last_q;
          end else begin
            pick = bus.req1_valid ? REQ1 : REQ0;
          end
          grant_d = pick;
          last_d  = pick;
          // The address register doubles as the latched operand copy, so
          // rom_addr naturally holds its value outside READ.
          addr_d  = (pick == REQ1) ? {bus.req1_a, bus.req1_b} : {bus.req0_a, bus.req0_b};
          rdy0    = (pick == REQ0);
          rdy1    = (pick == REQ1);
          state_d = READ;
        end
      end
      READ: begin
        rom_en  = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          result_d = bus.rom_dout;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        res = result_q;
        if (grant_q == REQ0) begin
          rv0 = 1'b1;
          if (bus.resp0_ready) begin
            state_d = IDLE;
          end
        end else begin
          rv1 = 1'b1;
          if (bus.resp1_ready) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readies are combinational from IDLE; masking with rst keeps every output
  // low while reset is held even if a requester is presenting.
  assign bus.req0_ready  = rdy0 & ~rst;
  assign bus.req1_ready  = rdy1 & ~rst;
  assign bus.resp0_valid = rv0;
  assign bus.resp1_valid = rv1;
  assign bus.resp_result = res;
  assign bus.rom_en      = rom_en;
  assign bus.rom_addr    = addr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: one instance with ROM_LATENCY=1 and one
// with ROM_LATENCY=3 (ROM output delayed by two extra registers). The stimulus
// is routed to the selected instance; the other sees idle requests.
module tb_mult_arbiter;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel3 = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   last_g = 1'b1;

  logic       r0v = 1'b0, r1v = 1'b0;
  logic [2:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic       rr0 = 1'b1, rr1 = 1'b1;

  logic       o_rdy0, o_rdy1, o_rv0, o_rv1, o_en, o_busy;
  logic [5:0] o_res, o_addr;

  logic [5:0] rom1_q, rom3_q, rom3_d1, rom3_d2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_arbiter_if i1 ();
  mult_arbiter_if i3 ();

  assign i1.req0_valid  = r0v & ~sel3;
  assign i1.req1_valid  = r1v & ~sel3;
  assign i3.req0_valid  = r0v & sel3;
  assign i3.req1_valid  = r1v & sel3;
  assign i1.req0_a = r0a;  assign i1.req0_b = r0b;
  assign i1.req1_a = r1a;  assign i1.req1_b = r1b;
  assign i3.req0_a = r0a;  assign i3.req0_b = r0b;
  assign i3.req1_a = r1a;  assign i3.req1_b = r1b;
  assign i1.resp0_ready = rr0;  assign i1.resp1_ready = rr1;
  assign i3.resp0_ready = rr0;  assign i3.resp1_ready = rr1;

  times_table_rom u_rom1 (.clk(clk), .en(i1.rom_en), .addr(i1.rom_addr), .dout(rom1_q));
  assign i1.rom_dout = rom1_q;

  times_table_rom u_rom3 (.clk(clk), .en(i3.rom_en), .addr(i3.rom_addr), .dout(rom3_q));
  always @(posedge clk) begin
    rom3_d1 <= rom3_q;
    rom3_d2 <= rom3_d1;
  end
  assign i3.rom_dout = rom3_d2;

  mult_arbiter #(.ROM_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  mult_arbiter #(.ROM_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(i3.slave));

  always_comb begin
    o_rdy0 = sel3 ? i3.req0_ready  : i1.req0_ready;
    o_rdy1 = sel3 ? i3.req1_ready  : i1.req1_ready;
    o_rv0  = sel3 ? i3.resp0_valid : i1.resp0_valid;
    o_rv1  = sel3 ? i3.resp1_valid : i1.resp1_valid;
    o_res  = sel3 ? i3.resp_result : i1.resp_result;
    o_en   = sel3 ? i3.rom_en      : i1.rom_en;
    o_addr = sel3 ? i3.rom_addr    : i1.rom_addr;
    o_busy = sel3 ? i3.busy        : i1.busy;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, lat%0d)", name, act, exp, cyc, sel3 ? 3 : 1);
    end
  endtask

  // Invariants that hold in every cycle outside reset.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("one_ready_max", int'(o_rdy0 && o_rdy1), 0);
      chk("ready_only_idle", int'((o_rdy0 || o_rdy1) && o_busy), 0);
      if (!o_rv0 && !o_rv1) chk("result_zero_no_resp", int'(o_res), 0);
    end
  end

  // Round-robin reference: starting after the last winner, the first pending requester wins.
  function automatic bit rr_model(input bit v0, input bit v1, input bit last);
    bit vld [2];
    bit w;
    vld[0] = v0;
    vld[1] = v1;
    w = last;
    for (int s = 2; s >= 1; s--) begin
      if (vld[(int'(last) + s) % 2]) w = bit'((int'(last) + s) % 2);
    end
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_req0_ready"}, int'(o_rdy0), 0);
    chk({tag, "_req1_ready"}, int'(o_rdy1), 0);
    chk({tag, "_resp0_valid"}, int'(o_rv0), 0);
    chk({tag, "_resp1_valid"}, int'(o_rv1), 0);
    chk({tag, "_resp_result"}, int'(o_res), 0);
    chk({tag, "_rom_en"}, int'(o_en), 0);
    chk({tag, "_rom_addr"}, int'(o_addr), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
  endtask

  // Leaves the bench just after a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r0v = 1'b0;
    r1v = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1;
  endtask

  // One full transaction. Must be called just after a negedge in an IDLE cycle.
  task automatic arb_txn(input bit v0, input bit v1,
                         input logic [2:0] a0, input logic [2:0] b0,
                         input logic [2:0] a1, input logic [2:0] b1,
                         input int hold, input bit eg, input logic [5:0] er,
                         output int t_acc);
    int lat;
    bit seen;
    int exp_lat;
    logic [5:0] exp_addr;
    exp_lat  = sel3 ? 5 : 3;
    exp_addr = eg ? {a1, b1} : {a0, b0};
    rr0 = (hold == 0);
    rr1 = (hold == 0);
    r0v = v0; r0a = a0; r0b = b0;
    r1v = v1; r1a = a1; r1b = b1;
    #1;
    t_acc = cyc;
    chk("accept_req0_ready", int'(o_rdy0), int'(eg == 1'b0));
    chk("accept_req1_ready", int'(o_rdy1), int'(eg == 1'b1));
    @(posedge clk); #1;
    // Operands change while valid stays up: only the latched copy may matter.
    r0a = 3'($urandom); r0b = 3'($urandom);
    r1a = 3'($urandom); r1b = 3'($urandom);
    @(negedge clk);
    chk("read_rom_en", int'(o_en), 1);
    chk("read_rom_addr", int'(o_addr), int'(exp_addr));
    chk("read_busy", int'(o_busy), 1);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (eg ? o_rv1 : o_rv0) seen = 1'b1;
      else chk("wait_busy", int'(o_busy), 1);
    end
    r0v = 1'b0;
    r1v = 1'b0;
    chk("resp_latency", lat, exp_lat);
    chk("resp_result", int'(o_res), int'(er));
    chk("resp_other_valid", int'(eg ? o_rv0 : o_rv1), 0);
    chk("resp_rom_en", int'(o_en), 0);
    chk("resp_rom_addr_held", int'(o_addr), int'(exp_addr));
    for (int i = 0; i < hold; i++) begin
      if (eg) r0v = 1'b1; else r1v = 1'b1;
      @(negedge clk);
      chk("stall_valid", int'(eg ? o_rv1 : o_rv0), 1);
      chk("stall_result", int'(o_res), int'(er));
      chk("stall_no_ready", int'(o_rdy0 || o_rdy1), 0);
    end
    r0v = 1'b0;
    r1v = 1'b0;
    rr0 = 1'b1;
    rr1 = 1'b1;
    @(negedge clk);
    chk("done_resp_valid", int'(o_rv0 || o_rv1), 0);
    chk("done_busy", int'(o_busy), 0);
    chk("done_result", int'(o_res), 0);
    last_g = eg;
  endtask

  task automatic rand_run(input int n);
    bit v0, v1, w;
    logic [2:0] a0, b0, a1, b1;
    int e, h, t;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(2))
        0: begin v0 = 1'b1; v1 = 1'b0; end
        1: begin v0 = 1'b0; v1 = 1'b1; end
        default: begin v0 = 1'b1; v1 = 1'b1; end
      endcase
      a0 = 3'($urandom); b0 = 3'($urandom);
      a1 = 3'($urandom); b1 = 3'($urandom);
      h = int'($urandom_range(3));
      w = rr_model(v0, v1, last_g);
      e = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
      arb_txn(v0, v1, a0, b0, a1, b1, h, w, 6'(e), t);
    end
  endtask

  typedef struct {
    bit         v0, v1;
    logic [2:0] a0, b0, a1, b1;
    int         hold;
    bit         eg;
    logic [5:0] er;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int t0, t1, t2, t3;
    int e;
    bit w;
    tbl[0] = '{1'b1, 1'b0, 3'd3, 3'd5, 3'd0, 3'd0, 0, 1'b0, 6'd15};
    tbl[1] = '{1'b1, 1'b1, 3'd7, 3'd7, 3'd2, 3'd6, 0, 1'b1, 6'd12};
    tbl[2] = '{1'b1, 1'b0, 3'd3, 3'd5, 3'd1, 3'd1, 0, 1'b0, 6'd15};
    tbl[3] = '{1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 3'd1, 0, 1'b1, 6'd7};
    tbl[4] = '{1'b1, 1'b1, 3'd7, 3'd0, 3'd5, 3'd5, 2, 1'b0, 6'd0};
    tbl[5] = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd6, 3'd7, 1, 1'b1, 6'd42};
    tbl[6] = '{1'b1, 1'b1, 3'd4, 3'd3, 3'd1, 3'd1, 0, 1'b0, 6'd12};
    tbl[7] = '{1'b1, 1'b1, 3'd1, 3'd1, 3'd7, 3'd7, 0, 1'b1, 6'd49};
    tbl[8] = '{1'b1, 1'b0, 3'd6, 3'd6, 3'd0, 3'd0, 0, 1'b0, 6'd36};

    do_reset();
    mon_en = 1'b1;

    // Simultaneous requests right after reset: requester 0 first (49), then 1 (12).
    arb_txn(1'b1, 1'b1, 3'd7, 3'd7, 3'd2, 3'd6, 0, 1'b0, 6'd49, t0);
    arb_txn(1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 3'd6, 0, 1'b1, 6'd12, t1);
    chk("both_second_back_to_back", t1 - t0, 4);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      arb_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
              tbl[i].hold, tbl[i].eg, tbl[i].er, t0);
    end

    // Requester 1 alone three times, back to back; then requester 0 must win.
    arb_txn(1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 3'd3, 0, 1'b1, 6'd9, t0);
    arb_txn(1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 3'd2, 0, 1'b1, 6'd10, t1);
    arb_txn(1'b0, 1'b1, 3'd0, 3'd0, 3'd7, 3'd6, 0, 1'b1, 6'd42, t2);
    arb_txn(1'b1, 1'b1, 3'd2, 3'd2, 3'd1, 3'd4, 0, 1'b0, 6'd4, t3);
    chk("p1_b2b_gap1", t1 - t0, 4);
    chk("p1_b2b_gap2", t2 - t1, 4);
    chk("p0_after_p1_gap", t3 - t2, 4);

    // Response held off for 5 cycles while requester 1 waits.
    arb_txn(1'b1, 1'b0, 3'd6, 3'd5, 3'd0, 3'd0, 5, 1'b1 ^ last_g ^ last_g ^ 1'b1, 6'd30, t0);

    // Reset pulsed in WAIT discards the transaction.
    r0v = 1'b1; r0a = 3'd3; r0b = 3'd3; rr0 = 1'b1;
    #1;
    chk("rstmid_accept", int'(o_rdy0), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_busy_in_wait", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    repeat (2) @(negedge clk);
    r0v = 1'b0;
    rst = 1'b0;
    last_g = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid_no_resp", int'(o_rv0 || o_rv1 || o_busy), 0);
    end
    arb_txn(1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 3'd4, 0, 1'b1, 6'd16, t0);

    rand_run(30);

    // Full operand sweep on both ROM latencies, alternating ports.
    for (int l = 0; l < 2; l++) begin
      mon_en = 1'b0;
      sel3 = (l == 1);
      do_reset();
      mon_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
        logic [5:0] idx;
        logic [2:0] a, b;
        idx = 6'(i);
        a = idx[5:3];
        b = idx[2:0];
        w = rr_model(~idx[0], idx[0], last_g);
        e = int'(a) * int'(b);
        arb_txn(~idx[0], idx[0], a, b, a, b, 0, w, 6'(e), t0);
      end
      rand_run(15);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter ROM_LATENCY, default 1, meaning the ROM read latency in cycles from en to valid dout (legal 1..3).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0_valid, req1_valid  input  1  requester N presents an operand pair.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  3  operands for requester N.
REQ-007 req0_ready, req1_ready  output  1  request from requester N accepted this cycle.
REQ-008 resp0_valid, resp1_valid  output  1  result held for requester N.
REQ-009 resp0_ready, resp1_ready  input  1  requester N consumes the result.
REQ-010 resp_result  output  6  product; valid only with respN_valid.
REQ-011 rom_en  output  1  ROM read enable.
REQ-012 rom_addr  output  6  ROM address, {a,b}.
REQ-013 rom_dout  input  6  ROM data, ROM_LATENCY cycles after rom_en.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, WAIT and RESP.
REQ-016 In IDLE, if any reqN_valid is high, SHALL grant one requester, assert reqN_ready for that requester combinationally in that cycle, latch its a and b, and go to READ.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not equal to last_grant; with one valid, grant it.
REQ-018 last_grant SHALL update on acceptance.
REQ-019 At most one reqN_ready SHALL be high in any cycle, and never outside IDLE.
REQ-020 READ SHALL last one cycle: rom_en=1, rom_addr={latched a, latched b}; then go to WAIT with the wait counter loaded to ROM_LATENCY-1.
REQ-021 rom_en SHALL be 0 in every state other than READ.
REQ-022 rom_addr SHALL hold its last value when rom_en=0.
REQ-023 WAIT SHALL decrement the counter each cycle; when the counter reaches 0, it SHALL capture rom_dout into the result register and go to RESP.
REQ-024 For ROM_LATENCY=1, WAIT lasts one cycle.
REQ-025 RESP SHALL assert respN_valid for the granted requester only, with resp_result stable, until respN_ready=1; then return to IDLE.
REQ-026 A new request MAY be accepted in the cycle after leaving RESP.
REQ-027 Latency SHALL be: accept at cycle T; respN_valid first high at T+2+ROM_LATENCY (T+3 for default).
REQ-028 respN_ready while respN_valid=0 SHALL be ignored.
REQ-029 reqN_valid deasserting outside IDLE SHALL have no effect; operands come from the latched copy.
REQ-030 resp_result SHALL be 0 whenever neither respN_valid is high.
REQ-031 Results SHALL be unsigned, 0..49, width 6, with no truncation.

Reset
REQ-032 On rst=1, the block SHALL immediately enter IDLE, with all outputs 0, the counter at 0, the result register at 0, and last_grant=1 (requester 0 wins first).
REQ-033 Reset mid-transaction SHALL discard the pending transaction with no response.
REQ-034 The first request after reset deassertion SHALL be accepted normally.

Structure
REQ-035 Shared package mult_pkg SHALL hold OPERAND_W=3, RESULT_W=6, ADDR_W=6, the FSM state encoding, and the requester IDs REQ0=0 and REQ1=1.
REQ-036 Sub-module times_table_rom (clk, en, addr[5:0], dout[5:0]) SHALL be a registered-output 64-entry ROM with content addr{a,b} -> a*b and latency 1.
REQ-037 The testbench SHALL connect times_table_rom to the rom_* ports; mult_arbiter itself contains no ROM.

Verification
REQ-038 Port 0 a=3, b=5 at T, resp0_ready held 1 -> req0_ready at T, rom_addr=6'o35 at T+1, resp0_valid with resp_result=15 at T+3 for one cycle.
REQ-039 Both valid at the same cycle, p0 7x7 and p1 2x6 -> p0 served first with 49, then p1 with 12; busy high throughout; never both readies high.
REQ-040 p1 continuously valid with p0 idle, 3 requests -> all served on p1 back-to-back (4 cycles each); p0 then raised -> p0 wins the next arbitration.
REQ-041 resp0_ready held 0 for 5 cycles in RESP -> resp0_valid and resp_result stay stable, and no reqN_ready is asserted during those cycles.
REQ-042 rst pulsed during WAIT -> all outputs 0 the same cycle and no response; the next p1 request 4x4 returns 16.
REQ-043 Exhaustive sweep of 64 operand pairs alternating ports, with ROM_LATENCY=1 and 3 -> every result equals a*b (0x0=0, 7x7=49), and latency matches REQ-027.
